// File: rtl/synth_pkg.sv
// Shared types, widths and saturating gain helpers for the voice envelope path.
package synth_pkg;

    localparam int unsigned GAIN_W  = 8;
    localparam int unsigned DUR_W   = 6;
    localparam int unsigned PRESC_W = 16;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ATTACK  = 3'd1;
    localparam logic [2:0] ST_DECAY   = 3'd2;
    localparam logic [2:0] ST_SUSTAIN = 3'd3;
    localparam logic [2:0] ST_RELEASE = 3'd4;

    typedef enum logic [2:0] {
        IDLE    = ST_IDLE,
        ATTACK  = ST_ATTACK,
        DECAY   = ST_DECAY,
        SUSTAIN = ST_SUSTAIN,
        RELEASE = ST_RELEASE
    } env_state_e;

    typedef logic [GAIN_W-1:0] gain_t;
    typedef logic [DUR_W-1:0]  dur_t;

    // One-bit-wider sum so a large increment clamps at the ceiling instead of wrapping.
    function automatic gain_t gain_up(input gain_t m, input gain_t inc, input gain_t ceil);
        logic [GAIN_W:0] sum;
        sum = {1'b0, m} + {1'b0, inc};
        gain_up = (sum >= {1'b0, ceil}) ? ceil : sum[GAIN_W-1:0];
    endfunction

    // Borrow bit catches underflow; result never drops below the floor.
    function automatic gain_t gain_down(input gain_t m, input gain_t dec, input gain_t floor);
        logic [GAIN_W:0] diff;
        diff = {1'b0, m} - {1'b0, dec};
        gain_down = (diff[GAIN_W] || (diff <= {1'b0, floor})) ? floor : diff[GAIN_W-1:0];
    endfunction

endpackage

// File: rtl/envelope_gen_step_prescaler.sv
// Counts sample strobes and emits a one-cycle envelope step every STEP_SAMPLES strobes.
module step_prescaler
    import synth_pkg::*;
#(
    parameter int unsigned STEP_SAMPLES = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic tick,
    output logic step
);

    logic [PRESC_W-1:0] cnt_q, cnt_d;
    logic               step_q, step_d;

    always_comb begin
        cnt_d  = cnt_q;
        step_d = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (en && tick) begin
            if (cnt_q == PRESC_W'(STEP_SAMPLES - 1)) begin
                cnt_d  = '0;
                step_d = 1'b1;
            end else begin
                cnt_d = cnt_q + PRESC_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            step_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            step_q <= step_d;
        end
    end

    assign step = step_q;

endmodule

// File: rtl/envelope_gen.sv
// Per-voice ADSR gain contour and note duration tracker feeding the dynamics stage.
module envelope_gen
    import synth_pkg::*;
#(
    parameter int unsigned STEP_SAMPLES = 256,
    parameter int unsigned MAX_LVL      = 255,
    parameter int unsigned ATTACK_STEP  = 32,
    parameter int unsigned DECAY_STEP   = 4,
    parameter int unsigned SUSTAIN_LVL  = 192,
    parameter int unsigned RELEASE_STEP = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              generate_next,
    input  logic              beat,
    input  logic              note_load,
    input  logic [DUR_W-1:0]  duration,
    output logic [DUR_W-1:0]  start,
    output logic [DUR_W-1:0]  curr,
    output logic [GAIN_W-1:0] multiple,
    output logic              active,
    output logic              done
);

    env_state_e state_q, state_d;
    dur_t       start_q, start_d;
    dur_t       curr_q, curr_d;
    gain_t      mult_q, mult_d;
    logic       active_q, active_d;
    logic       done_q, done_d;
    logic       step;
    logic       load_c;

    assign load_c = note_load && (duration != '0);

    step_prescaler #(
        .STEP_SAMPLES(STEP_SAMPLES)
    ) u_presc (
        .clk (clk),
        .rst (rst),
        .clr (load_c),
        .en  (active_q),
        .tick(generate_next),
        .step(step)
    );

    always_comb begin
        state_d = state_q;
        start_d = start_q;
        curr_d  = curr_q;
        mult_d  = mult_q;
        done_d  = 1'b0;
        if (load_c) begin
            // Gain is kept so a retrigger ramps from the current level.
            start_d = duration;
            curr_d  = duration;
            state_d = ATTACK;
        end else begin
            if (step) begin
                case (state_q)
                    ATTACK: begin
                        mult_d = gain_up(mult_q, gain_t'(ATTACK_STEP), gain_t'(MAX_LVL));
                        if (mult_d == gain_t'(MAX_LVL)) state_d = DECAY;
                    end
                    DECAY: begin
                        mult_d = gain_down(mult_q, gain_t'(DECAY_STEP), gain_t'(SUSTAIN_LVL));
                        if (mult_d == gain_t'(SUSTAIN_LVL)) state_d = SUSTAIN;
                    end
                    RELEASE: begin
                        mult_d = gain_down(mult_q, gain_t'(RELEASE_STEP), '0);
                        if (mult_d == '0) state_d = IDLE;
                    end
                    default: ;
                endcase
            end
            // Note end overrides any step-driven transition; the step's gain still lands.
            if (beat && (state_q != IDLE) && (curr_q != '0)) begin
                curr_d = curr_q - dur_t'(1);
                if (curr_q == dur_t'(1)) begin
                    done_d  = 1'b1;
                    state_d = RELEASE;
                end
            end
        end
        active_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            start_q  <= '0;
            curr_q   <= '0;
            mult_q   <= '0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            start_q  <= start_d;
            curr_q   <= curr_d;
            mult_q   <= mult_d;
            active_q <= active_d;
            done_q   <= done_d;
        end
    end

    assign start    = start_q;
    assign curr     = curr_q;
    assign multiple = mult_q;
    assign active   = active_q;
    assign done     = done_q;

endmodule
